sampler_seq_scheduler: RTL and testbench

Record/playback scheduler for the keyboard sampler. It captures one-hot note presses from the PS/2 keyboard tracker into two fixed-depth tracks and replays them at a fixed tempo. A single note bus feeds the tone/LED stage, and this block arbitrates that bus between live keys and the two playback tracks. It sits between keyboard_tracker and the note output stage, and replaces ad-hoc switch decoding.

---
 rtl/sampler_seq_scheduler.sv | 168 ++++++++++++++++
 tb/tb_sampler_seq_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampler_seq_scheduler.sv
// rtl/sampler_seq_scheduler.sv - record/playback note scheduler with live-key arbitration
// Optional build macro LOOP_EN: playback tracks wrap instead of finishing.
module sampler_seq_scheduler #(
  parameter int NOTES    = 9,
  parameter int DEPTH    = 9,
  parameter int TICK_DIV = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NOTES-1:0] key_notes,
  input  logic [1:0]       rec_sel,
  input  logic [1:0]       play_sel,
  output logic [NOTES-1:0] note_out,
  output logic [1:0]       state,
  output logic [3:0]       count0,
  output logic [3:0]       count1,
  output logic             full
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REC  = 2'b01;
  localparam logic [1:0] S_PLAY = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam int          TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]  DEPTH_C   = 4'(DEPTH);

  logic [NOTES-1:0] trk0 [DEPTH];
  logic [NOTES-1:0] trk1 [DEPTH];

  logic [NOTES-1:0] key_prev;
  logic [NOTES-1:0] play_reg;
  logic [3:0]       ptr0, ptr1;
  logic [TW-1:0]    tick;
  logic             rr;
  logic [1:0]       rec_code;
  logic [1:0]       play_code;

  logic             key_valid, press, rec_req, play_req, step;
  logic             act0, act1, serve0, serve1, rec_store;
  logic [3:0]       rec_cnt, ptr0_next, ptr1_next;
  logic [NOTES-1:0] live, play_hit;

  always_comb begin
    key_valid = (key_notes != '0) && ((key_notes & (key_notes - NOTES'(1))) == '0);
    press     = key_valid && (key_notes != key_prev);
    live      = key_valid ? key_notes : '0;
    rec_req   = (rec_sel == 2'b01) || (rec_sel == 2'b10);
    play_req  = (play_sel != 2'b00);
    step      = (tick == '0);
    rec_cnt   = rec_code[1] ? count1 : count0;
    full      = (state == S_REC) && (rec_cnt == DEPTH_C);
    rec_store = (state == S_REC) && (rec_sel == rec_code) && !play_req &&
                press && (rec_cnt != DEPTH_C);
`ifdef LOOP_EN
    act0      = play_sel[0] && (count0 != 4'd0);
    act1      = play_sel[1] && (count1 != 4'd0);
    ptr0_next = (ptr0 + 4'd1 >= count0) ? 4'd0 : ptr0 + 4'd1;
    ptr1_next = (ptr1 + 4'd1 >= count1) ? 4'd0 : ptr1 + 4'd1;
`else
    act0      = play_sel[0] && (ptr0 < count0);
    act1      = play_sel[1] && (ptr1 < count1);
    ptr0_next = ptr0 + 4'd1;
    ptr1_next = ptr1 + 4'd1;
`endif
    // rr=0 prefers track0; it only matters when both tracks compete
    serve0    = act0 && (!act1 || !rr);
    serve1    = act1 && !serve0;
    play_hit  = serve0 ? trk0[ptr0] : trk1[ptr1];
  end

  always_ff @(posedge clk) begin
    if (rec_store) begin
      if (rec_code[1]) trk1[rec_cnt] <= key_notes;
      else             trk0[rec_cnt] <= key_notes;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      note_out  <= '0;
      count0    <= 4'd0;
      count1    <= 4'd0;
      ptr0      <= 4'd0;
      ptr1      <= 4'd0;
      tick      <= '0;
      rr        <= 1'b0;
      play_reg  <= '0;
      key_prev  <= '0;
      rec_code  <= 2'b00;
      play_code <= 2'b00;
    end else begin
      key_prev <= key_notes;
      case (state)
        S_IDLE: begin
          note_out <= live;
          if (rec_req && !play_req) begin
            state    <= S_REC;
            rec_code <= rec_sel;
            if (rec_sel[1]) count1 <= 4'd0;
            else            count0 <= 4'd0;
          end else if (play_req && !rec_req) begin
            state     <= S_PLAY;
            play_code <= play_sel;
            ptr0      <= 4'd0;
            ptr1      <= 4'd0;
            tick      <= '0;
            rr        <= 1'b0;
            play_reg  <= '0;
          end
        end
        S_REC: begin
          note_out <= live;
          if ((rec_sel != rec_code) || play_req) begin
            state <= S_IDLE;
          end else if (rec_store) begin
            if (rec_code[1]) count1 <= count1 + 4'd1;
            else             count0 <= count0 + 4'd1;
          end
        end
        S_PLAY: begin
          if (!play_req || rec_req) begin
            state    <= S_IDLE;
            note_out <= live;
          end else begin
            tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
            if (step) begin
              if (serve0 || serve1) begin
                play_reg <= play_hit;
                note_out <= key_valid ? key_notes : play_hit;
                if (serve0) begin
                  ptr0 <= ptr0_next;
                  rr   <= 1'b1;
                end else begin
                  ptr1 <= ptr1_next;
                  rr   <= 1'b0;
                end
              end else begin
                state    <= S_DONE;
                play_reg <= '0;
                note_out <= live;
              end
            end else begin
              note_out <= key_valid ? key_notes : play_reg;
            end
          end
        end
        default: begin
          note_out <= live;
          if (!play_req) begin
            state <= S_IDLE;
          end else if (play_sel != play_code) begin
            state     <= S_PLAY;
            play_code <= play_sel;
            ptr0      <= 4'd0;
            ptr1      <= 4'd0;
            tick      <= '0;
            rr        <= 1'b0;
            play_reg  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sampler_seq_scheduler.sv
// tb/tb_sampler_seq_scheduler.sv - randomized self-checking bench for sampler_seq_scheduler
module tb_sampler_seq_scheduler;
  localparam int NOTES = 9, DEPTH = 9, TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NOTES-1:0] key_notes;
  logic [1:0]       rec_sel, play_sel;
  logic [NOTES-1:0] note_out;
  logic [1:0]       state;
  logic [3:0]       count0, count1;
  logic             full;

  int checks = 0;
  int failures = 0;

  logic [NOTES-1:0] m0[$];
  logic [NOTES-1:0] m1[$];
  logic [NOTES-1:0] plist[$];

  sampler_seq_scheduler #(.NOTES(NOTES), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .key_notes(key_notes), .rec_sel(rec_sel),
    .play_sel(play_sel), .note_out(note_out), .state(state),
    .count0(count0), .count1(count1), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [NOTES-1:0] onehot(int i);
    logic [NOTES-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit is_valid(logic [NOTES-1:0] v);
    return $countones(v) == 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    key_notes = '0; rec_sel = 2'b00; play_sel = 2'b00;
    reset = 1'b1;
    #12;
    checks++;
    if ({note_out, state, count0, count1, full} !== {9'd0, 2'b00, 4'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset got note=%b st=%b c0=%0d c1=%0d full=%b", note_out, state, count0, count1, full);
    end
    @(negedge clk);
    reset = 1'b0;
    m0.delete(); m1.delete();
    cyc();
    checks++;
    if (state !== 2'b00 || note_out !== '0) begin
      failures++;
      $display("FAIL reset_release got st=%b note=%b exp st=00 note=0", state, note_out);
    end
  endtask

  // Records plist into track t; each press held `hold` cycles (0 = random 1..3).
  task automatic record_track(int t, int hold, bit add_multi);
    int h;
    rec_sel = (t == 1) ? 2'b10 : 2'b01;
    key_notes = '0;
    cyc(); cyc();
    if (t == 1) m1.delete(); else m0.delete();
    checks++;
    if (state !== 2'b01 || (t == 1 ? count1 : count0) !== 4'd0) begin
      failures++;
      $display("FAIL rec_entry got st=%b cnt=%0d exp st=01 cnt=0", state, (t == 1 ? count1 : count0));
    end
    foreach (plist[i]) begin
      key_notes = plist[i];
      h = (hold > 0) ? hold : $urandom_range(1, 3);
      for (int j = 0; j < h; j++) begin
        cyc();
        checks++;
        if (note_out !== plist[i]) begin
          failures++;
          $display("FAIL rec_echo got=%b exp=%b", note_out, plist[i]);
        end
      end
      if (t == 1) begin if (m1.size() < DEPTH) m1.push_back(plist[i]); end
      else        begin if (m0.size() < DEPTH) m0.push_back(plist[i]); end
      key_notes = '0;
      cyc();
    end
    if (add_multi) begin
      key_notes = onehot(8) | onehot(7);
      cyc(); cyc();
      checks++;
      if (note_out !== '0) begin
        failures++;
        $display("FAIL rec_multi_echo got=%b exp=0", note_out);
      end
      key_notes = '0;
      cyc();
    end
    checks++;
    if ((t == 1 ? count1 : count0) !== 4'((t == 1) ? m1.size() : m0.size())) begin
      failures++;
      $display("FAIL rec_count got=%0d exp=%0d", (t == 1 ? count1 : count0), (t == 1 ? m1.size() : m0.size()));
    end
    checks++;
    if (full !== (((t == 1) ? m1.size() : m0.size()) == DEPTH)) begin
      failures++;
      $display("FAIL rec_full got=%b exp=%b", full, (((t == 1) ? m1.size() : m0.size()) == DEPTH));
    end
    rec_sel = 2'b00;
    cyc();
    checks++;
    if (state !== 2'b00 || count0 !== 4'(m0.size()) || count1 !== 4'(m1.size())) begin
      failures++;
      $display("FAIL rec_exit got st=%b c0=%0d c1=%0d exp st=00 c0=%0d c1=%0d", state, count0, count1, m0.size(), m1.size());
    end
  endtask

  task automatic random_plist(int n);
    plist.delete();
    for (int i = 0; i < n; i++) plist.push_back(onehot($urandom_range(0, NOTES - 1)));
  endtask

  // Starts playback from IDLE or DONE and checks every cycle against the track model.
  task automatic run_play(logic [1:0] psel, bit with_live);
    logic [NOTES-1:0] seq[$];
    logic [NOTES-1:0] last_key, play_val, exp;
    int p0, p1, pref, c, done_step, total, ls, le;
    bit a0, a1, done_now;
    p0 = 0; p1 = 0; pref = 0; done_step = -1;
    for (int s = 0; s < 40; s++) begin
`ifdef LOOP_EN
      a0 = psel[0] && (m0.size() > 0);
      a1 = psel[1] && (m1.size() > 0);
`else
      a0 = psel[0] && (p0 < m0.size());
      a1 = psel[1] && (p1 < m1.size());
`endif
      if (!a0 && !a1) begin done_step = s; break; end
      c = (a0 && a1) ? pref : (a0 ? 0 : 1);
      if (c == 0) begin seq.push_back(m0[p0]); p0++; if (p0 >= m0.size()) p0 = 0; end
      else        begin seq.push_back(m1[p1]); p1++; if (p1 >= m1.size()) p1 = 0; end
`ifndef LOOP_EN
      if (c == 0 && p0 == 0) p0 = m0.size();
      if (c == 1 && p1 == 0) p1 = m1.size();
`endif
      pref = 1 - c;
    end
    total = (done_step >= 0) ? 4 * done_step + 4 : 48;
    ls = $urandom_range(2, total > 4 ? total - 2 : 2);
    le = ls + $urandom_range(1, 6);
    play_sel = psel;
    key_notes = '0;
    last_key = '0;
    for (int n = 0; n <= total; n++) begin
      cyc();
      done_now = (done_step >= 0) && (n >= 1 + 4 * done_step);
      play_val = (n == 0 || done_now) ? '0 : seq[(n - 1) / 4];
      exp = is_valid(last_key) ? last_key : play_val;
      checks++;
      if (note_out !== exp) begin
        failures++;
        $display("FAIL play_note cyc=%0d psel=%b got=%b exp=%b", n, psel, note_out, exp);
      end
      checks++;
      if (state !== (done_now ? 2'b11 : 2'b10)) begin
        failures++;
        $display("FAIL play_state cyc=%0d got=%b exp=%b", n, state, (done_now ? 2'b11 : 2'b10));
      end
      key_notes = (with_live && n >= ls && n < le) ? onehot(1) : '0;
      last_key = key_notes;
    end
    key_notes = '0;
  endtask

  task automatic go_idle();
    play_sel = 2'b00; rec_sel = 2'b00; key_notes = '0;
    cyc(); cyc();
    checks++;
    if (state !== 2'b00 || note_out !== '0) begin
      failures++;
      $display("FAIL go_idle got st=%b note=%b exp st=00 note=0", state, note_out);
    end
  endtask

  task automatic test_record_example();
    plist.delete();
    plist.push_back(onehot(8)); plist.push_back(onehot(7)); plist.push_back(onehot(6));
    record_track(0, 3, 1'b0);
  endtask

  task automatic test_record_full();
    random_plist(10);
    record_track(1, 0, 1'b1);
  endtask

  task automatic test_conflict();
    rec_sel = 2'b01; play_sel = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (state !== 2'b00 || count0 !== 4'(m0.size())) begin
        failures++;
        $display("FAIL conflict got st=%b c0=%0d exp st=00 c0=%0d", state, count0, m0.size());
      end
    end
    go_idle();
  endtask

  task automatic test_play_example();
    plist.delete(); plist.push_back(onehot(8)); plist.push_back(onehot(7));
    record_track(0, 2, 1'b0);
    plist.delete(); plist.push_back(onehot(0));
    record_track(1, 2, 1'b0);
    run_play(2'b11, 1'b0);
    go_idle();
    run_play(2'b11, 1'b1);
    go_idle();
  endtask

  task automatic test_play_empty();
    plist.delete();
    record_track(0, 1, 1'b0);
    run_play(2'b01, 1'b0);
    go_idle();
  endtask

  task automatic test_done_reentry();
    random_plist(3);
    record_track(0, 0, 1'b0);
    plist.delete();
    record_track(1, 1, 1'b0);
    run_play(2'b10, 1'b0);
    run_play(2'b01, 1'b0);
    go_idle();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      random_plist($urandom_range(0, DEPTH));
      record_track(0, 0, 1'b0);
      random_plist($urandom_range(0, DEPTH));
      record_track(1, 0, ($urandom_range(0, 1) == 1));
      run_play(2'($urandom_range(1, 3)), ($urandom_range(0, 1) == 1));
      go_idle();
    end
  endtask

  task automatic test_async_reset();
    random_plist(4);
    record_track(0, 0, 1'b0);
    play_sel = 2'b01;
    cyc(); cyc(); cyc();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({note_out, state, count0, count1, full} !== {9'd0, 2'b00, 4'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got note=%b st=%b c0=%0d c1=%0d", note_out, state, count0, count1);
    end
    play_sel = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    m0.delete(); m1.delete();
    cyc();
  endtask

  initial begin
    test_reset();
    test_record_example();
    test_record_full();
    test_conflict();
    test_play_example();
    test_play_empty();
    test_done_reentry();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
